// File: rtl/cache_trace_issuer.sv
// Trace-command issuer: buffers trace entries in a FIFO and issues them one at a time to the cache.
// Optional WAIT timeout is compiled in with `define ISSUER_TIMEOUT_EN.
module cache_trace_issuer #(
  parameter int DEPTH        = 4,
  parameter int GUARD_CYCLES = 2,
  parameter int TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_n,
  input  logic [31:0] in_address,
  output logic [3:0]  cache_n,
  output logic [31:0] cache_address,
  output logic        cache_valid,
  input  logic        cache_done,
  output logic        busy,
  output logic [15:0] issued_cntr,
  output logic [7:0]  drop_cntr,
  output logic        timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    GUARD = 2'd3
  } state_t;

  // Codes with no cache meaning are counted and discarded without using FIFO storage.
  function automatic logic is_illegal(input logic [3:0] code);
    logic res;
    case (code)
      4'd7, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15: res = 1'b1;
      default:                                         res = 1'b0;
    endcase
    return res;
  endfunction

  state_t          state_r, state_n;
  logic [AW:0]     wr_ptr_r, rd_ptr_r;
  logic [3:0]      mem_n_r    [DEPTH];
  logic [31:0]     mem_addr_r [DEPTH];
  logic [3:0]      cmd_n_r;
  logic [31:0]     cmd_addr_r;
  logic            cache_valid_r;
  logic [15:0]     issued_cntr_r;
  logic [7:0]      drop_cntr_r;
  logic [GW-1:0]   guard_cnt_r;
  logic            empty_s, full_s, push_s, pop_s, drop_s, expire_s;

  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign drop_s  = in_valid & is_illegal(in_n);
  assign push_s  = in_valid & ~full_s & ~is_illegal(in_n);
  assign pop_s   = (state_r == IDLE) & ~empty_s;

  assign in_ready      = ~full_s;
  assign cache_n       = cmd_n_r;
  assign cache_address = cmd_addr_r;
  assign cache_valid   = cache_valid_r;
  assign busy          = (state_r != IDLE) | ~empty_s;
  assign issued_cntr   = issued_cntr_r;
  assign drop_cntr     = drop_cntr_r;

`ifdef ISSUER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt_r;
  logic          timeout_r;

  // A done in the expiry cycle wins, so no abandon is flagged then.
  assign expire_s = (state_r == WAIT) & ~cache_done & (wait_cnt_r == TW'(TIMEOUT - 1));
  assign timeout  = timeout_r;

  // WAIT cycle counter and abandon pulse.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wait_cnt_r <= '0;
      timeout_r  <= 1'b0;
    end else begin
      timeout_r <= expire_s;
      if (state_r == WAIT) begin
        wait_cnt_r <= wait_cnt_r + TW'(1);
      end else begin
        wait_cnt_r <= '0;
      end
    end
  end
`else
  assign expire_s = 1'b0;
  assign timeout  = 1'b0;
`endif

  // FSM next-state decode.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (!empty_s) state_n = ISSUE;
        else          state_n = IDLE;
      end
      ISSUE: begin
        case (cmd_n_r)
          4'd8, 4'd9: state_n = GUARD;
          default:    state_n = WAIT;
        endcase
      end
      WAIT: begin
        if (cache_done || expire_s) state_n = IDLE;
        else                        state_n = WAIT;
      end
      GUARD: begin
        if (guard_cnt_r == GUARD_LAST) state_n = IDLE;
        else                           state_n = GUARD;
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM state, command register, issue strobe and guard counter.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_r       <= IDLE;
      cmd_n_r       <= 4'd0;
      cmd_addr_r    <= 32'd0;
      cache_valid_r <= 1'b0;
      guard_cnt_r   <= '0;
    end else begin
      state_r       <= state_n;
      cache_valid_r <= (state_n == ISSUE);
      if (pop_s) begin
        cmd_n_r    <= mem_n_r[rd_ptr_r[AW-1:0]];
        cmd_addr_r <= mem_addr_r[rd_ptr_r[AW-1:0]];
      end
      if (state_r == GUARD) begin
        guard_cnt_r <= guard_cnt_r + GW'(1);
      end else begin
        guard_cnt_r <= '0;
      end
    end
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_n_r[i]    <= 4'd0;
        mem_addr_r[i] <= 32'd0;
      end
    end else begin
      if (push_s) begin
        mem_n_r[wr_ptr_r[AW-1:0]]    <= in_n;
        mem_addr_r[wr_ptr_r[AW-1:0]] <= in_address;
        wr_ptr_r                     <= wr_ptr_r + (AW+1)'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
    end
  end

  // Saturating issue and drop statistics.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      issued_cntr_r <= 16'd0;
      drop_cntr_r   <= 8'd0;
    end else begin
      if ((state_r == ISSUE) && (issued_cntr_r != 16'hFFFF)) begin
        issued_cntr_r <= issued_cntr_r + 16'd1;
      end
      if (drop_s && (drop_cntr_r != 8'hFF)) begin
        drop_cntr_r <= drop_cntr_r + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_cache_trace_issuer.sv
// Self-checking bench for cache_trace_issuer: scoreboard on issued commands plus table-driven and timing sequences.
module tb_cache_trace_issuer;

  localparam int GUARD_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_n = 4'd0;
  logic [31:0] in_address = 32'd0;
  logic [3:0]  cache_n;
  logic [31:0] cache_address;
  logic        cache_valid;
  logic        cache_done = 1'b0;
  logic        busy;
  logic [15:0] issued_cntr;
  logic [7:0]  drop_cntr;
  logic        timeout;

  cache_trace_issuer #(.DEPTH(4), .GUARD_CYCLES(GUARD_CYCLES), .TIMEOUT(64)) dut (
    .clk(clk), .rstb(rstb), .in_valid(in_valid), .in_ready(in_ready), .in_n(in_n),
    .in_address(in_address), .cache_n(cache_n), .cache_address(cache_address),
    .cache_valid(cache_valid), .cache_done(cache_done), .busy(busy),
    .issued_cntr(issued_cntr), .drop_cntr(drop_cntr), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int strobe_cnt = 0;
  int exp_issued = 0;
  int exp_drop = 0;
  logic [35:0] sb_q[$];

  typedef struct {
    logic [3:0]  n;
    logic [31:0] addr;
    logic        exp_drop;
    logic        exp_guard;
  } vec_t;
  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Every issue strobe must match the oldest accepted legal entry.
  always @(negedge clk) begin
    if (rstb && cache_valid) begin
      strobe_cnt++;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe actual=%0h_%0h expected=none", cache_n, cache_address);
      end else begin
        logic [35:0] e;
        e = sb_q.pop_front();
        if ({cache_n, cache_address} !== e) begin
          failures++;
          $display("FAIL issue_order actual=%0h expected=%0h", {cache_n, cache_address}, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] n, input logic [31:0] a);
    logic ill, acc;
    ill = (n == 4'd7) || (n >= 4'd10);
    in_valid = 1'b1; in_n = n; in_address = a;
    acc = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) begin
      acc = in_ready | ill;
      if (acc && !ill) sb_q.push_back({n, a});
      tick();
    end
    in_valid = 1'b0;
    if (!acc) check("push_accept", 32'd0, 32'd1);
  endtask

  task automatic wait_strobe(input string name);
    int c;
    c = 0;
    while (!cache_valid && c < 50) begin tick(); c++; end
    check(name, {31'd0, cache_valid}, 32'd1);
  endtask

  // Pulse done in the current WAIT cycle; optionally expect the next strobe 2 cycles later.
  task automatic done_pulse(input logic expect_next);
    int c;
    cache_done = 1'b1; tick(); cache_done = 1'b0;
    c = 1;
    if (expect_next) begin
      while (!cache_valid && c < 20) begin tick(); c++; end
      check("b2b_gap", c, 32'd2);
    end
  endtask

  initial begin
    vecs[0]  = '{4'd0,  32'h0000_0000, 1'b0, 1'b0};
    vecs[1]  = '{4'd1,  32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[2]  = '{4'd2,  32'hA5A5_5A5A, 1'b0, 1'b0};
    vecs[3]  = '{4'd3,  32'h0000_0004, 1'b0, 1'b0};
    vecs[4]  = '{4'd4,  32'h1234_5678, 1'b0, 1'b0};
    vecs[5]  = '{4'd5,  32'h8000_0000, 1'b0, 1'b0};
    vecs[6]  = '{4'd6,  32'h7FFF_FFFC, 1'b0, 1'b0};
    vecs[7]  = '{4'd7,  32'h0000_0700, 1'b1, 1'b0};
    vecs[8]  = '{4'd8,  32'hDEAD_BEEF, 1'b0, 1'b1};
    vecs[9]  = '{4'd9,  32'h0000_0900, 1'b0, 1'b1};
    vecs[10] = '{4'd10, 32'h0000_0A00, 1'b1, 1'b0};
    vecs[11] = '{4'd11, 32'h0000_0B00, 1'b1, 1'b0};
    vecs[12] = '{4'd12, 32'h0000_0C00, 1'b1, 1'b0};
    vecs[13] = '{4'd13, 32'h0000_0D00, 1'b1, 1'b0};
    vecs[14] = '{4'd14, 32'h0000_0E00, 1'b1, 1'b0};
    vecs[15] = '{4'd15, 32'h0000_0F00, 1'b1, 1'b0};

    // Reset values
    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_valid", {31'd0, cache_valid}, 32'd0);
    check("rst_n", {28'd0, cache_n}, 32'd0);
    check("rst_addr", cache_address, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_issued", {16'd0, issued_cntr}, 32'd0);
    check("rst_drop", {24'd0, drop_cntr}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    #10 rstb = 1'b1;
    tick();

    // Single-entry latency
    push(4'd0, 32'h0000_1040);
    check("lat_no_strobe_t", {31'd0, cache_valid}, 32'd0);
    tick();
    check("lat_strobe", {31'd0, cache_valid}, 32'd1);
    check("lat_addr", cache_address, 32'h0000_1040);
    tick();
    exp_issued++;
    check("lat_single_cycle", {31'd0, cache_valid}, 32'd0);
    check("lat_issued", {16'd0, issued_cntr}, exp_issued);
    repeat (3) begin
      check("lat_busy_wait", {31'd0, busy}, 32'd1);
      tick();
    end
    done_pulse(1'b0);
    check("lat_busy_done", {31'd0, busy}, 32'd0);

    // Fill: 1 in flight + 4 buffered, then illegal codes while full
    push(4'd1, 32'h0000_0100);
    push(4'd2, 32'h0000_0200);
    push(4'd3, 32'h0000_0300);
    push(4'd4, 32'h0000_0400);
    push(4'd5, 32'h0000_0500);
    check("fill_in_ready_low", {31'd0, in_ready}, 32'd0);
    begin
      int s0;
      s0 = strobe_cnt;
      push(4'd7, 32'hBAD0_0007);
      push(4'd12, 32'hBAD0_000C);
      exp_drop += 2;
      tick();
      check("full_drop_cntr", {24'd0, drop_cntr}, exp_drop);
      check("full_no_strobe", strobe_cnt, s0);
      check("full_still_full", {31'd0, in_ready}, 32'd0);
    end
    done_pulse(1'b1);
    check("fill_in_ready_rise", {31'd0, in_ready}, 32'd1);
    repeat (3) begin tick(); done_pulse(1'b1); end
    tick(); done_pulse(1'b0);
    exp_issued += 5;
    check("fill_issued", {16'd0, issued_cntr}, exp_issued);
    check("fill_sb_empty", sb_q.size(), 32'd0);

    // GUARD pacing: n=8 then n=1 with no done
    push(4'd8, 32'h0000_0800);
    push(4'd1, 32'h0000_0110);
    wait_strobe("guard_first");
    begin
      int c;
      c = 0;
      tick(); c++;
      while (!cache_valid && c < 20) begin tick(); c++; end
      check("guard_gap", c, GUARD_CYCLES + 2);
    end
    tick(); done_pulse(1'b0);
    exp_issued += 2;
    check("guard_issued", {16'd0, issued_cntr}, exp_issued);

    // Table of every command code
    for (int i = 0; i < 16; i++) begin
      int s0;
      s0 = strobe_cnt;
      push(vecs[i].n, vecs[i].addr);
      if (vecs[i].exp_drop) begin
        exp_drop++;
        repeat (3) tick();
        check("tbl_drop_cntr", {24'd0, drop_cntr}, exp_drop);
        check("tbl_drop_no_strobe", strobe_cnt, s0);
      end else begin
        wait_strobe("tbl_strobe");
        exp_issued++;
        tick();
        check("tbl_issued", {16'd0, issued_cntr}, exp_issued);
        if (vecs[i].exp_guard) repeat (GUARD_CYCLES) tick();
        else done_pulse(1'b0);
        check("tbl_idle", {31'd0, busy}, 32'd0);
      end
    end

`ifdef ISSUER_TIMEOUT_EN
    // Timeout abandon, then done exactly on the expiry cycle
    begin
      int c;
      push(4'd4, 32'h0000_4000);
      wait_strobe("to_strobe");
      tick();
      c = 0;
      while (!timeout && c < 100) begin tick(); c++; end
      check("to_latency", c, 32'd64);
      tick();
      check("to_single_pulse", {31'd0, timeout}, 32'd0);
      check("to_idle", {31'd0, busy}, 32'd0);
      push(4'd4, 32'h0000_4004);
      wait_strobe("to2_strobe");
      tick();
      repeat (63) tick();
      cache_done = 1'b1; tick(); cache_done = 1'b0;
      check("to_done_wins", {31'd0, timeout}, 32'd0);
      tick();
      check("to_done_wins_late", {31'd0, timeout}, 32'd0);
      check("to2_idle", {31'd0, busy}, 32'd0);
    end
`endif

    // Drop counter saturation
    for (int i = 0; i < 260; i++) push(4'd13, i);
    tick();
    check("drop_saturate", {24'd0, drop_cntr}, 32'd255);

    // Asynchronous reset mid-WAIT with 3 buffered entries
    push(4'd1, 32'h0000_0A01);
    push(4'd2, 32'h0000_0A02);
    push(4'd3, 32'h0000_0A03);
    push(4'd4, 32'h0000_0A04);
    tick();
    check("rw_busy_before", {31'd0, busy}, 32'd1);
    rstb = 1'b0;
    #1;
    sb_q.delete();
    check("rw_in_ready", {31'd0, in_ready}, 32'd1);
    check("rw_valid", {31'd0, cache_valid}, 32'd0);
    check("rw_n", {28'd0, cache_n}, 32'd0);
    check("rw_addr", cache_address, 32'd0);
    check("rw_busy", {31'd0, busy}, 32'd0);
    check("rw_issued", {16'd0, issued_cntr}, 32'd0);
    check("rw_drop", {24'd0, drop_cntr}, 32'd0);
    #2 rstb = 1'b1;
    begin
      int s0;
      s0 = strobe_cnt;
      repeat (10) tick();
      check("rw_no_stale", strobe_cnt, s0);
      check("rw_busy_after", {31'd0, busy}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_trace_issuer.md
# cache_trace_issuer

Trace-command issuer for the L1 cache model. Accepts trace entries (command code `n` plus 32-bit address) from the trace-file front end through a valid/ready handshake and buffers them in a small FIFO. Drives them one at a time onto the cache's `n`/`address`/`valid` inputs, pacing issue on the cache's operation-finished pulse. It is the transmitting end of the cache command interface and owns command legality filtering, issue pacing and issue statistics.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `GUARD_CYCLES`, 2, idle cycles after a fire-and-forget command (n=8/9); ≥1.
- `TIMEOUT`, 64, max cycles in WAIT before abandoning a command (only with `ISSUER_TIMEOUT_EN`).
- `clk`  in  1  clock, rising edge.
- `rstb`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  trace entry offered.
- `in_ready`  out  1  FIFO can accept (= not full).
- `in_n`  in  4  trace command code.
- `in_address`  in  32  trace address.
- `cache_n`  out  4  command code to cache.
- `cache_address`  out  32  address to cache.
- `cache_valid`  out  1  single-cycle issue strobe.
- `cache_done`  in  1  cache operation-finished pulse.
- `busy`  out  1  FSM not in IDLE, or FIFO non-empty.
- `issued_cntr`  out  16  commands issued, saturating.
- `drop_cntr`  out  8  illegal codes discarded, saturating.
- `timeout`  out  1  single-cycle pulse on abandon.

## Operation
- Push on `in_valid & in_ready` at a rising edge. Codes 7 and 10–15 are accepted but not stored; `drop_cntr` increments and the entry is never issued. These codes are accepted even when the FIFO is full (`in_ready` low), because they take no storage.
- FIFO: read/write pointers of log2(DEPTH)+1 bits. Full = MSBs differ and LSBs are equal. Pointers wrap naturally.
- FSM states: IDLE, ISSUE, WAIT, GUARD.
  - IDLE: if the FIFO is non-empty, pop the head into the command register and go to ISSUE.
  - ISSUE: `cache_valid`=1 for exactly this cycle, and `issued_cntr` increments. Codes 0–6 go to WAIT. Codes 8 and 9 go to GUARD.
  - WAIT: on `cache_done`, go to IDLE.
  - GUARD: count `GUARD_CYCLES`, then go to IDLE. No `cache_done` is expected here, because n=8 clears the cache asynchronously.
- `cache_n` and `cache_address` are driven from the command register. They stay stable from ISSUE until the next pop.
- `cache_done` is ignored outside WAIT.
- `issued_cntr` and `drop_cntr` saturate at all-ones; they do not wrap.
- n=8 clears only the cache. The issuer's FIFO, counters and FSM are unaffected.

## Timing
- Reset values:
  - `in_ready`=1.
  - `cache_valid`=0.
  - `cache_n`=0, `cache_address`=0.
  - `busy`=0.
  - `issued_cntr`=0, `drop_cntr`=0.
  - `timeout`=0.
  - FSM=IDLE, FIFO empty.
- Latency: an entry accepted at edge t into an empty FIFO with the FSM in IDLE is popped at edge t+1. `cache_valid` is then high during cycle t+1→t+2.
- Back-to-back issue: the earliest next `cache_valid` is 2 cycles after the `cache_done` cycle (WAIT→IDLE→ISSUE).
- GUARD path: the next `cache_valid` is `GUARD_CYCLES`+2 cycles after the n=8/9 strobe.
- Push and pop in the same cycle are allowed, and occupancy is unchanged. `in_ready` is combinational from registered pointers only.
- Asynchronous reset mid-WAIT or mid-GUARD abandons the command and empties the FIFO. No `cache_valid` is produced in the reset cycle.

## Configuration
- `ISSUER_TIMEOUT_EN` defined:
  - A WAIT cycle counter runs. On reaching `TIMEOUT` cycles without `cache_done`, the FSM goes to IDLE and `timeout` pulses for 1 cycle.
  - `cache_done` in the same cycle as expiry counts as completion, and there is no timeout pulse.
- `ISSUER_TIMEOUT_EN` undefined:
  - WAIT lasts indefinitely.
  - `timeout` is tied to 0, the counter is not instantiated, and `TIMEOUT` is unused.

## Test plan
- Reset, then push n=0, addr=0x0000_1040 → `cache_valid` one cycle at t+1; `cache_n`=0, `cache_address`=0x0000_1040; `issued_cntr`=1; `busy` stays high until `cache_done`.
- Push 5 entries with `cache_done` held low, DEPTH=4 → `in_ready` drops after the 5th accept (1 in flight + 4 buffered). Pulse `cache_done` → `in_ready` rises; entries issue in order.
- Push n=7 and n=12 with the FIFO full → both accepted; `drop_cntr`=2; no `cache_valid`; FIFO contents unchanged.
- Push n=8 then n=1 → `cache_valid` for n=8, then no strobe for `GUARD_CYCLES`=2 cycles, then n=1 strobe 4 cycles after the first, with no `cache_done` needed in between.
- With `ISSUER_TIMEOUT_EN`, issue n=4 and never assert `cache_done` → `timeout` pulses exactly 64 cycles after WAIT entry, then the next entry issues. Repeat with `cache_done` on the expiry cycle → no pulse.
- Assert `rstb`=0 mid-WAIT with 3 entries buffered → all outputs return to reset values immediately; after release, no stale command is issued.
